// File: rtl/line_sensor_decoder_pkg.sv
// line_pkg: shared FSM encodings, default thresholds and steering-error codes
// for the line sensor decoder.
package line_pkg;
    typedef enum logic [1:0] {FOLLOW = 2'd0, NODE = 2'd1, LOST = 2'd2} state_t;

    localparam logic [11:0] TH_HI_DEF = 12'd2000;
    localparam logic [11:0] TH_LO_DEF = 12'd1600;

    localparam logic [2:0] ERR_M2 = 3'b110;
    localparam logic [2:0] ERR_M1 = 3'b111;
    localparam logic [2:0] ERR_0  = 3'b000;
    localparam logic [2:0] ERR_P1 = 3'b001;
    localparam logic [2:0] ERR_P2 = 3'b010;

    // Ambiguous patterns (111, 000, 101) keep the last steering error.
    function automatic logic [2:0] pos_err_of(input logic [2:0] lb, input logic [2:0] prev);
        return lb == 3'b010 ? ERR_0  :
               lb == 3'b110 ? ERR_M1 :
               lb == 3'b100 ? ERR_M2 :
               lb == 3'b011 ? ERR_P1 :
               lb == 3'b001 ? ERR_P2 : prev;
    endfunction
endpackage

// File: rtl/line_sensor_decoder_hyst_cmp.sv
// hyst_cmp: per-channel hysteresis comparator; next on/off bit from the
// current value and the previous bit.
module hyst_cmp #(
    parameter logic [11:0] TH_HI = 12'd2000,
    parameter logic [11:0] TH_LO = 12'd1600
) (
    input  logic [11:0] value,
    input  logic        prev,
    output logic        on
);
    assign on = prev ? (value >= TH_LO) : (value >= TH_HI);
endmodule

// File: rtl/line_sensor_decoder.sv
// line_sensor_decoder: stable-capture filter, hysteresis, debounce, steering
// error and FOLLOW/NODE/LOST tracking for a three-channel line sensor.
module line_sensor_decoder
    import line_pkg::*;
#(
    parameter logic [11:0] TH_HI    = TH_HI_DEF,
    parameter logic [11:0] TH_LO    = TH_LO_DEF,
    parameter int unsigned DEB      = 3,
    parameter int unsigned LOST_LIM = 8
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic [11:0] d_out_ch1,
    input  logic [11:0] d_out_ch3,
    input  logic [11:0] d_out_ch4,
    output logic [2:0]  line_bits,
    output logic [2:0]  pos_err,
    output logic        node_pulse,
    output logic [7:0]  node_count,
    output logic        lost,
    output logic [1:0]  state,
    output logic        valid
);
    logic [35:0] cap;
    logic        s1, busy, take, accept, enter;
    logic [2:0]  raw, raw_n, cand, cand_n, lb_n;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  off, off_n;
    state_t      st_q, st_n;

    // Busy covers the processing cycle and the valid cycle.
    assign busy   = s1 | valid;
    assign take   = sample_tick & ~busy;
    assign accept = take & ({d_out_ch1, d_out_ch3, d_out_ch4} == cap);

    hyst_cmp #(.TH_HI(TH_HI), .TH_LO(TH_LO)) u_hyst_l (.value(cap[35:24]), .prev(raw[2]), .on(raw_n[2]));
    hyst_cmp #(.TH_HI(TH_HI), .TH_LO(TH_LO)) u_hyst_c (.value(cap[23:12]), .prev(raw[1]), .on(raw_n[1]));
    hyst_cmp #(.TH_HI(TH_HI), .TH_LO(TH_LO)) u_hyst_r (.value(cap[11:0]),  .prev(raw[0]), .on(raw_n[0]));

    assign cand_n = raw_n;
    assign cnt_n  = raw_n != cand ? 4'd1 : cnt >= 4'(DEB) ? 4'(DEB) : cnt + 4'd1;
    assign lb_n   = cnt_n == 4'(DEB) ? cand_n : line_bits;
    assign off_n  = lb_n != 3'b000 ? 8'd0 : off == 8'hFF ? 8'hFF : off + 8'd1;

    always_comb begin
        st_n = st_q;
        if (s1) begin
            case (st_q)
                FOLLOW:  st_n = lb_n == 3'b111 ? NODE : off_n >= 8'(LOST_LIM) ? LOST : FOLLOW;
                NODE:    st_n = (lb_n != 3'b111 && lb_n != 3'b000) ? FOLLOW :
                                off_n >= 8'(LOST_LIM) ? LOST : NODE;
                LOST:    st_n = lb_n == 3'b111 ? NODE : lb_n != 3'b000 ? FOLLOW : LOST;
                default: st_n = FOLLOW;
            endcase
        end
    end

    assign enter = (st_n == NODE) && (st_q != NODE);
    assign lost  = st_q == LOST;
    assign state = st_q;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            st_q <= FOLLOW;
        else
            st_q <= st_n;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cap        <= '0;
            s1         <= 1'b0;
            valid      <= 1'b0;
            node_pulse <= 1'b0;
            raw        <= '0;
            cand       <= '0;
            cnt        <= '0;
            off        <= '0;
            line_bits  <= '0;
            pos_err    <= '0;
            node_count <= '0;
        end else begin
            s1         <= accept;
            valid      <= s1;
            node_pulse <= enter;
            if (take)
                cap <= {d_out_ch1, d_out_ch3, d_out_ch4};
            if (s1) begin
                raw       <= raw_n;
                cand      <= cand_n;
                cnt       <= cnt_n;
                off       <= off_n;
                line_bits <= lb_n;
                pos_err   <= pos_err_of(lb_n, pos_err);
                if (enter)
                    node_count <= node_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_line_sensor_decoder.sv
// tb_line_sensor_decoder: directed stimulus with a behavioural model feeding a
// scoreboard queue that is drained on each valid pulse.
module tb_line_sensor_decoder;
    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic [11:0] d_out_ch1 = '0, d_out_ch3 = '0, d_out_ch4 = '0;
    logic [2:0]  line_bits, pos_err;
    logic        node_pulse, lost, valid;
    logic [7:0]  node_count;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [2:0] lb;
        logic [2:0] pe;
        logic [1:0] st;
        logic       np;
        logic [7:0] nc;
        logic       lost;
    } exp_t;
    exp_t q[$];

    logic [35:0] m_cap;
    logic [2:0]  m_raw, m_cand, m_lb, m_pe;
    int          m_cnt, m_off, m_st;
    logic [7:0]  m_nc;

    always #5 clk_50M = ~clk_50M;

    line_sensor_decoder dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .sample_tick(sample_tick),
        .d_out_ch1(d_out_ch1), .d_out_ch3(d_out_ch3), .d_out_ch4(d_out_ch4),
        .line_bits(line_bits), .pos_err(pos_err), .node_pulse(node_pulse),
        .node_count(node_count), .lost(lost), .state(state), .valid(valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cap = '0; m_raw = '0; m_cand = '0; m_lb = '0; m_pe = '0;
        m_cnt = 0; m_off = 0; m_st = 0; m_nc = '0;
        q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_lb"}, 32'(line_bits), 0);
        chk({tag, "_pe"}, 32'(pos_err), 0);
        chk({tag, "_np"}, 32'(node_pulse), 0);
        chk({tag, "_nc"}, 32'(node_count), 0);
        chk({tag, "_lost"}, 32'(lost), 0);
        chk({tag, "_st"}, 32'(state), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
    endtask

    // Spec-level model of one accepted sample; pushes the expected outputs.
    task automatic model_step(input logic [11:0] v[3]);
        logic [2:0] rn;
        int nxt;
        exp_t e;
        for (int i = 0; i < 3; i++)
            rn[2-i] = m_raw[2-i] ? (v[i] >= 12'd1600) : (v[i] >= 12'd2000);
        m_raw = rn;
        if (rn == m_cand) m_cnt = (m_cnt >= 3) ? 3 : m_cnt + 1;
        else begin m_cand = rn; m_cnt = 1; end
        if (m_cnt == 3) m_lb = m_cand;
        case (m_lb)
            3'b010: m_pe = 3'b000;
            3'b110: m_pe = 3'b111;
            3'b100: m_pe = 3'b110;
            3'b011: m_pe = 3'b001;
            3'b001: m_pe = 3'b010;
            default: ;
        endcase
        m_off = (m_lb == 3'b000) ? ((m_off == 255) ? 255 : m_off + 1) : 0;
        nxt = m_st;
        if (m_st == 0) nxt = (m_lb == 3'b111) ? 1 : (m_off >= 8) ? 2 : 0;
        else if (m_st == 1) nxt = (m_lb != 3'b111 && m_lb != 3'b000) ? 0 : (m_off >= 8) ? 2 : 1;
        else nxt = (m_lb == 3'b111) ? 1 : (m_lb != 3'b000) ? 0 : 2;
        e.np = (nxt == 1 && m_st != 1);
        if (e.np) m_nc = m_nc + 8'd1;
        m_st = nxt;
        e.lb = m_lb; e.pe = m_pe; e.st = 2'(m_st); e.nc = m_nc; e.lost = (m_st == 2);
        q.push_back(e);
    endtask

    // One tick with full-window checking; hold2 keeps sample_tick high an extra cycle.
    task automatic tick(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r, input bit hold2 = 0);
        logic [11:0] v[3];
        bit acc;
        exp_t e;
        v[0] = l; v[1] = c; v[2] = r;
        @(negedge clk_50M);
        d_out_ch1 = l; d_out_ch3 = c; d_out_ch4 = r; sample_tick = 1'b1;
        acc = ({l, c, r} == m_cap);
        m_cap = {l, c, r};
        if (acc) model_step(v);
        @(negedge clk_50M);
        if (!hold2) sample_tick = 1'b0;
        chk("valid_early", 32'(valid), 0);
        @(negedge clk_50M);
        sample_tick = 1'b0;
        chk("valid", 32'(valid), 32'(acc));
        if (valid && q.size() > 0) begin
            e = q.pop_front();
            chk("line_bits", 32'(line_bits), 32'(e.lb));
            chk("pos_err", 32'(pos_err), 32'(e.pe));
            chk("state", 32'(state), 32'(e.st));
            chk("node_pulse", 32'(node_pulse), 32'(e.np));
            chk("node_count", 32'(node_count), 32'(e.nc));
            chk("lost", 32'(lost), 32'(e.lost));
        end
        @(negedge clk_50M);
        chk("valid_late", 32'(valid), 0);
        chk("node_pulse_late", 32'(node_pulse), 0);
    endtask

    task automatic ticks(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r, input int n);
        for (int i = 0; i < n; i++) tick(l, c, r);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk_50M);
        check_zero("reset");
        rst_n = 1'b1;
        // Centre on: first capture discarded, then DEB accepted samples settle 010.
        ticks(12'd100, 12'd3000, 12'd100, 4);
        chk("centre_lb", 32'(line_bits), 32'(3'b010));
        chk("centre_pe", 32'(pos_err), 0);
        // Hysteresis on the centre channel.
        ticks(12'd100, 12'd1800, 12'd100, 4);
        chk("hyst_1800_on", 32'(line_bits), 32'(3'b010));
        ticks(12'd100, 12'd1500, 12'd100, 4);
        chk("hyst_1500_off", 32'(line_bits), 32'(3'b000));
        ticks(12'd100, 12'd1800, 12'd100, 4);
        chk("hyst_1800_off", 32'(line_bits), 32'(3'b000));
        chk("hold_pe", 32'(pos_err), 0);
        // Unstable captures are discarded.
        tick(12'd3000, 12'd3000, 12'd3000);
        tick(12'd100, 12'd100, 12'd100);
        // All-off run enters LOST, a centred sample recovers.
        ticks(12'd100, 12'd100, 12'd100, 9);
        chk("lost_set", 32'(lost), 1);
        chk("lost_state", 32'(state), 2);
        ticks(12'd100, 12'd3000, 12'd100, 4);
        chk("recover_state", 32'(state), 0);
        chk("recover_lost", 32'(lost), 0);
        // Steering error codes.
        ticks(12'd3000, 12'd3000, 12'd100, 4);
        chk("pe_m1", 32'(pos_err), 32'(3'b111));
        ticks(12'd100, 12'd100, 12'd3000, 4);
        chk("pe_p2", 32'(pos_err), 32'(3'b010));
        // A tick held into the busy window is ignored.
        tick(12'd100, 12'd100, 12'd3000, 1);
        // Node entry, then wrap the node count.
        ticks(12'd3000, 12'd3000, 12'd3000, 6);
        chk("node_state", 32'(state), 1);
        chk("node_count1", 32'(node_count), 1);
        for (int i = 0; i < 255; i++) begin
            ticks(12'd100, 12'd3000, 12'd100, 4);
            ticks(12'd3000, 12'd3000, 12'd3000, 4);
        end
        chk("node_wrap", 32'(node_count), 0);
        chk("node_wrap_state", 32'(state), 1);
        // Reset pulsed between tick and valid.
        @(negedge clk_50M);
        sample_tick = 1'b1;
        @(negedge clk_50M);
        sample_tick = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        @(negedge clk_50M);
        check_zero("midreset");
        @(negedge clk_50M);
        chk("midreset_valid2", 32'(valid), 0);
        chk("sb_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_sensor_decoder.md
LINE_SENSOR_DECODER -- requirements
Module: line_sensor_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-002 Parameter TH_HI, default 12'd2000, is the on-line threshold; a channel is "on" once its value is >= TH_HI.
REQ-003 Parameter TH_LO, default 12'd1600, is the off-line threshold; an "on" channel turns "off" once its value is < TH_LO.
REQ-004 Parameter DEB, default 3, is the number of identical consecutive raw patterns needed to update line_bits (range 1..15).
REQ-005 Parameter LOST_LIM, default 8, is the number of consecutive all-off debounced samples that enter LOST (range 1..255).
REQ-006 Ports SHALL be:
- clk_50M  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle strobe; new ADC frame available.
- d_out_ch1  in  12  left sensor value.
- d_out_ch3  in  12  centre sensor value.
- d_out_ch4  in  12  right sensor value.
- line_bits  out  3  debounced {L,C,R}; 1 = on line.
- pos_err  out  3  signed steering error, -2..+2.
- node_pulse  out  1  one-cycle pulse when a node is entered.
- node_count  out  8  count of nodes since reset.
- lost  out  1  high while in LOST.
- state  out  2  FOLLOW=0, NODE=1, LOST=2.
- valid  out  1  one-cycle pulse when outputs are updated.

Function
REQ-007 On sample_tick, all three channels SHALL be captured into a holding register. A capture SHALL be accepted only if it equals the previous capture on every channel; otherwise it is discarded and no further processing runs for that tick.
REQ-008 Per-channel hysteresis: off->on when value >= TH_HI; on->off when value < TH_LO; otherwise the bit is held. The result is the raw pattern.
REQ-009 Debounce: if the raw pattern equals the candidate pattern, increment a 4-bit counter, saturating at DEB; else load the raw pattern as the new candidate and set the counter to 1. When the counter reaches DEB, line_bits SHALL be updated to the candidate.
REQ-010 pos_err SHALL be derived combinationally from line_bits and registered with line_bits:
- 010 = 0; 110 = -1; 100 = -2; 011 = +1; 001 = +2.
- 111, 000 and 101 hold the previous value.
REQ-011 valid SHALL pulse exactly 2 clk_50M cycles after an accepted sample_tick, whether or not line_bits changed.
REQ-012 FSM:
- FOLLOW -> NODE when line_bits becomes 111.
- NODE -> FOLLOW when line_bits is not 111 and not 000.
- NODE -> LOST via the all-off count.
- FOLLOW -> LOST when LOST_LIM consecutive accepted samples give line_bits = 000.
- LOST -> FOLLOW on any accepted sample with line_bits other than 000 or 111.
- LOST -> NODE directly on 111.
REQ-013 On each entry to NODE, node_pulse SHALL assert for one cycle, coincident with valid, and node_count SHALL increment, wrapping from 255 to 0. Remaining in NODE SHALL NOT re-pulse.
REQ-014 The all-off counter SHALL be 8 bits and saturating. It clears on any accepted sample whose line_bits is not 000.
REQ-015 A sample_tick arriving while the 2-cycle pipeline is busy SHALL be ignored.
REQ-016 lost SHALL equal (state == LOST).

Reset
REQ-017 When rst_n is low, all outputs SHALL reset to 0, state SHALL reset to FOLLOW, and the capture, candidate and counters SHALL clear, regardless of the clock.
REQ-018 Reset deassertion mid-pipeline SHALL produce no valid pulse or node_pulse until a fresh accepted sample arrives.

Structure
REQ-019 The state encodings, default thresholds and pos_err codes SHALL live in a shared package, line_pkg.
REQ-020 Per-channel hysteresis SHALL be one sub-module, hyst_cmp, instantiated three times.

Verification
REQ-021 Tick pairs with {L,C,R} = {100,3000,100}, repeated DEB times -> line_bits = 010, pos_err = 0, valid on each accepted tick.
REQ-022 Centre held on, centre value stepped 3000 -> 1800 -> 1500 -> 1800 -> bit stays on at 1800, goes off at 1500, stays off at the second 1800.
REQ-023 Differing consecutive captures {3000..} then {100..} -> first capture discarded, no valid.
REQ-024 Pattern 111 held for 5 stable samples -> one node_pulse, node_count 0 -> 1, state = NODE; node_count preset to 255 then a node -> node_count = 0.
REQ-025 Line_bits = 000 for 8 accepted samples -> lost asserts on the 8th; then a 010 sample -> state = FOLLOW, lost = 0.
REQ-026 rst_n pulsed low between sample_tick and valid -> no valid pulse, all outputs 0, state = FOLLOW.
